// File: rtl/swm_cfg_loader_if.sv
// -----------------------------------------------------------------------------
// swm_cfg_loader_if
// Bundles the configuration port handshake and the live route-select bus of
// one switch-matrix tile loader.
//   start      : pulse, begin loading a new frame
//   cfg_in     : serial frame data, MSB first
//   cfg_valid  : cfg_in qualifier
//   busy       : loader is not idle
//   done       : one-cycle pulse, frame committed
//   err        : one-cycle pulse, frame rejected
//   err_code   : 0 none, 1 illegal side, 2 index out of range, 3 parity
//   err_entry  : number of the first failing entry
//   cfg_bus    : live routing configuration, entry k at [6k+5:6k]
// Modports: master = configuration port controller, slave = loader.
// -----------------------------------------------------------------------------
interface swm_cfg_loader_if #(
    parameter int N_TB    = 5,
    parameter int N_LR    = 4,
    parameter int ENTRY_W = 6
);
    localparam int CFG_W = (2 * N_TB + 2 * N_LR) * ENTRY_W;

    logic             start;
    logic             cfg_in;
    logic             cfg_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [4:0]       err_entry;
    logic [CFG_W-1:0] cfg_bus;

    modport master (
        output start, cfg_in, cfg_valid,
        input  busy, done, err, err_code, err_entry, cfg_bus
    );

    modport slave (
        input  start, cfg_in, cfg_valid,
        output busy, done, err, err_code, err_entry, cfg_bus
    );
endinterface

// File: rtl/swm_cfg_loader.sv
// -----------------------------------------------------------------------------
// swm_cfg_loader
// Serial configuration loader for one switch-matrix tile. A frame is shifted
// MSB-first into a shadow register, every route entry is range-checked one per
// cycle, and only a clean frame is copied in one step onto the live cfg_bus.
// A rejected frame leaves cfg_bus untouched.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears cfg_bus too)
//   bus   : swm_cfg_loader_if.slave (start/cfg_in/cfg_valid in,
//           busy/done/err/err_code/err_entry/cfg_bus out)
// Optional feature: define SWM_CFG_PARITY_EN to append one even-parity bit to
// each frame; it is checked in a PAR state before the entry scan.
// -----------------------------------------------------------------------------
module swm_cfg_loader #(
    parameter int N_TB    = 5,
    parameter int N_LR    = 4,
    parameter int ENTRY_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    swm_cfg_loader_if.slave      bus
);
    localparam int NUM_ENT = 2 * N_TB + 2 * N_LR;
    localparam int CFG_W   = NUM_ENT * ENTRY_W;
    localparam int CNT_W   = $clog2(CFG_W + 1);
    localparam int PTR_W   = $clog2(NUM_ENT);
    localparam int IDX_W   = ENTRY_W - 3;

    // One extra bit so the limit itself is representable for any N_TB/N_LR.
    localparam logic [IDX_W:0] TB_LIM = (IDX_W + 1)'(N_TB);
    localparam logic [IDX_W:0] LR_LIM = (IDX_W + 1)'(N_LR);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
`ifdef SWM_CFG_PARITY_EN
        PAR,
`endif
        CHECK,
        COMMIT,
        FAIL
    } state_t;

    state_t           state_reg;
    logic [CFG_W-1:0] shadow_reg;
    logic [CFG_W-1:0] cfg_bus_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [PTR_W-1:0] ptr_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;
    logic [1:0]       err_code_reg;
    logic [4:0]       err_entry_reg;
`ifdef SWM_CFG_PARITY_EN
    logic             parity_reg;
`endif

    // Slice the shadow register into route entries for the scan mux.
    logic [ENTRY_W-1:0] entry_arr [NUM_ENT];
    generate
        for (genvar gi = 0; gi < NUM_ENT; gi++) begin : g_entry
            assign entry_arr[gi] = shadow_reg[gi*ENTRY_W +: ENTRY_W];
        end
    endgenerate

    logic [ENTRY_W-1:0] cur_entry;
    logic [2:0]         cur_side;
    logic [IDX_W:0]     cur_idx;
    logic               side_bad;
    logic               idx_bad;

    always_comb begin
        cur_entry = entry_arr[ptr_reg];
        cur_side  = cur_entry[2:0];
        cur_idx   = {1'b0, cur_entry[ENTRY_W-1:3]};
        side_bad  = (cur_side > 3'd4);
        idx_bad   = 1'b0;
        case (cur_side)
            3'd1, 3'd3: idx_bad = (cur_idx >= TB_LIM);
            3'd2, 3'd4: idx_bad = (cur_idx >= LR_LIM);
            default:    idx_bad = 1'b0;  // float ignores the index; 5..7 caught by side_bad
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            shadow_reg    <= '0;
            cfg_bus_reg   <= '0;
            bit_cnt_reg   <= '0;
            ptr_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= 2'd0;
            err_entry_reg <= 5'd0;
`ifdef SWM_CFG_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg     <= LOAD;
                        busy_reg      <= 1'b1;
                        bit_cnt_reg   <= '0;
                        err_code_reg  <= 2'd0;
                        err_entry_reg <= 5'd0;
`ifdef SWM_CFG_PARITY_EN
                        parity_reg    <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (bus.cfg_valid) begin
                        shadow_reg  <= {shadow_reg[CFG_W-2:0], bus.cfg_in};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
`ifdef SWM_CFG_PARITY_EN
                        parity_reg  <= parity_reg ^ bus.cfg_in;
`endif
                        if (bit_cnt_reg == CNT_W'(CFG_W - 1)) begin
`ifdef SWM_CFG_PARITY_EN
                            state_reg <= PAR;
`else
                            state_reg <= CHECK;
                            ptr_reg   <= '0;
`endif
                        end
                    end
                end
`ifdef SWM_CFG_PARITY_EN
                PAR: begin
                    if (bus.cfg_valid) begin
                        if (bus.cfg_in != parity_reg) begin
                            state_reg     <= FAIL;
                            err_reg       <= 1'b1;
                            err_code_reg  <= 2'd3;
                            err_entry_reg <= 5'd0;
                        end else begin
                            state_reg <= CHECK;
                            ptr_reg   <= '0;
                        end
                    end
                end
`endif
                CHECK: begin
                    // Outputs are registered, so done/err and the commit are
                    // launched on the transition into COMMIT/FAIL.
                    if (side_bad || idx_bad) begin
                        state_reg     <= FAIL;
                        err_reg       <= 1'b1;
                        err_code_reg  <= side_bad ? 2'd1 : 2'd2;
                        err_entry_reg <= 5'(ptr_reg);
                    end else if (ptr_reg == PTR_W'(NUM_ENT - 1)) begin
                        state_reg   <= COMMIT;
                        cfg_bus_reg <= shadow_reg;
                        done_reg    <= 1'b1;
                    end else begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end
                end
                COMMIT: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                FAIL: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
    assign bus.err_code  = err_code_reg;
    assign bus.err_entry = err_entry_reg;
    assign bus.cfg_bus   = cfg_bus_reg;

endmodule

// File: tb/tb_swm_cfg_loader.sv
module tb_swm_cfg_loader;
    localparam int CFG_W = 108;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    swm_cfg_loader_if #(.N_TB(5), .N_LR(4), .ENTRY_W(6)) bus_if ();

    swm_cfg_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    typedef struct {
        bit               is_err;
        logic [1:0]       code;
        logic [4:0]       entry;
        logic [CFG_W-1:0] bus;
        int               lat;
    } exp_t;

    exp_t             sb[$];
    logic [CFG_W-1:0] committed = '0;
    int               checks = 0;
    int               errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [CFG_W-1:0] set_ent(input logic [CFG_W-1:0] f, input int k, input logic [5:0] v);
        logic [CFG_W-1:0] r;
        r = f;
        r[6*k +: 6] = v;
        return r;
    endfunction

    // Reference model: scan entries in order, first fault wins.
    function automatic exp_t model(input logic [CFG_W-1:0] f, input bit flip_par, input int last_cycle);
        exp_t e;
        logic [2:0] side;
        logic [2:0] idx;
        e.is_err = 1'b0;
        e.code   = 2'd0;
        e.entry  = 5'd0;
        e.bus    = f;
        e.lat    = last_cycle + 19;
        if (flip_par) begin
            e.is_err = 1'b1;
            e.code   = 2'd3;
            e.lat    = last_cycle + 1;
        end else begin
            for (int k = 0; k < 18; k++) begin
                side = f[6*k +: 3];
                idx  = f[6*k+3 +: 3];
                if (side > 3'd4) begin
                    e.is_err = 1'b1; e.code = 2'd1;
                end else if ((side == 3'd1 || side == 3'd3) && idx >= 3'd5) begin
                    e.is_err = 1'b1; e.code = 2'd2;
                end else if ((side == 3'd2 || side == 3'd4) && idx >= 3'd4) begin
                    e.is_err = 1'b1; e.code = 2'd2;
                end
                if (e.is_err) begin
                    e.entry = 5'(k);
                    e.lat   = last_cycle + 2 + k;
                    break;
                end
            end
        end
        if (e.is_err) e.bus = committed;
        return e;
    endfunction

    task automatic run_frame(input string name, input logic [CFG_W-1:0] f, input bit flip_par, input bit gapped);
        exp_t       e;
        exp_t       x;
        logic [108:0] stream;
        int         nbits;
        int         sent;
        int         last;
        int         lat;
        bit         found;
`ifdef SWM_CFG_PARITY_EN
        nbits  = 109;
        stream = {f, ^f ^ flip_par};
`else
        nbits  = 108;
        stream = {1'b0, f};
`endif
        last = gapped ? (2 * nbits - 1) : nbits;
        e = model(f, flip_par, last);
        sb.push_back(e);
        if (!e.is_err) committed = f;

        @(negedge clk);
        bus_if.start     = 1'b1;
        bus_if.cfg_valid = 1'b0;
        sent  = 0;
        found = 1'b0;
        lat   = 0;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check({name, " busy_after_start"}, 128'(bus_if.busy), 128'(1));
                check({name, " err_code_cleared"}, 128'(bus_if.err_code), 128'(0));
            end
            if (bus_if.done || bus_if.err) begin
                found = 1'b1;
                lat   = n;
                break;
            end
            bus_if.start = gapped && (n % 5 == 2);
            if (sent < nbits && (!gapped || n % 2 == 1)) begin
                bus_if.cfg_in    = stream[nbits - 1 - sent];
                bus_if.cfg_valid = 1'b1;
                sent++;
            end else begin
                bus_if.cfg_in    = 1'($urandom);
                bus_if.cfg_valid = 1'b0;
            end
        end
        bus_if.start     = 1'b0;
        bus_if.cfg_valid = 1'b0;
        x = sb.pop_front();
        check({name, " completion_seen"}, 128'(found), 128'(1));
        if (found) begin
            check({name, " done_err"}, 128'({bus_if.err, bus_if.done}), 128'({x.is_err, !x.is_err}));
            check({name, " err_code"}, 128'(bus_if.err_code), 128'(x.code));
            check({name, " err_entry"}, 128'(bus_if.err_entry), 128'(x.entry));
            check({name, " cfg_bus"}, 128'(bus_if.cfg_bus), 128'(x.bus));
            check({name, " latency"}, 128'(lat), 128'(x.lat));
            @(negedge clk);
            check({name, " idle_after"}, 128'({bus_if.busy, bus_if.done, bus_if.err}), 128'(0));
            check({name, " err_code_held"}, 128'(bus_if.err_code), 128'(x.code));
        end
        $display("frame %s: lat=%0d done=%0b err=%0b code=%0d entry=%0d", name, lat,
                 !x.is_err, x.is_err, bus_if.err_code, bus_if.err_entry);
    endtask

    logic [CFG_W-1:0] fa, fb, fc, fd, fe, ff;

    initial begin
        bus_if.start     = 1'b0;
        bus_if.cfg_in    = 1'b0;
        bus_if.cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 128'({bus_if.busy, bus_if.done, bus_if.err, bus_if.err_code, bus_if.err_entry}), 128'(0));
        check("reset_cfg_bus", 128'(bus_if.cfg_bus), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        fa = set_ent(set_ent('0, 0, 6'h0B), 14, 6'h1C);
        fb = set_ent(fa, 10, 6'h22);                       // right, idx 4
        fc = set_ent(set_ent('0, 3, 6'h07), 5, 6'h31);     // side 7, then top idx 6
        fd = set_ent(set_ent(set_ent(fa, 9, 6'h23), 17, 6'h1A), 16, 6'h38); // legal boundaries, float ignores idx
        fe = set_ent(fd, 17, 6'h24);                       // left idx 4 in last entry
        ff = set_ent(fd, 12, 6'h3D);                       // side 5 and idx 7 in same entry

        run_frame("zero", '0, 1'b0, 1'b0);
        run_frame("frameA", fa, 1'b0, 1'b0);
        check("frameA entry0", 128'(bus_if.cfg_bus[5:0]), 128'(6'h0B));
        check("frameA entry14", 128'(bus_if.cfg_bus[89:84]), 128'(6'h1C));
        run_frame("idx_fault_e10", fb, 1'b0, 1'b0);
        run_frame("side_first_e3", fc, 1'b0, 1'b0);
        run_frame("gapped_starts", fd, 1'b0, 1'b1);
        run_frame("idx_fault_e17", fe, 1'b0, 1'b0);
        run_frame("side_prio_e12", ff, 1'b0, 1'b0);
        run_frame("frameA_again", fa, 1'b0, 1'b0);

        // Abort a frame with reset after 50 bits.
        @(negedge clk);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            bus_if.cfg_in    = 1'($urandom);
            bus_if.cfg_valid = 1'b1;
            @(negedge clk);
        end
        check("abort busy_before_reset", 128'(bus_if.busy), 128'(1));
        rst_n = 1'b0;
        #1;
        check("abort cfg_bus", 128'(bus_if.cfg_bus), 128'(0));
        check("abort busy", 128'(bus_if.busy), 128'(0));
        $display("abort: reset after 50 bits, cfg_bus=%0h busy=%0b", bus_if.cfg_bus, bus_if.busy);
        bus_if.cfg_valid = 1'b0;
        committed = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_frame("after_reset", fd, 1'b0, 1'b0);
`ifdef SWM_CFG_PARITY_EN
        run_frame("parity_flip", fa, 1'b1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/swm_cfg_loader.md
Name: swm_cfg_loader

Overview:
- Serial configuration loader and sequencer for one switch-matrix tile: 5 top, 5 bottom, 4 left and 4 right wires, 18 route entries of 6 bits each.
- Shifts a configuration frame into a shadow register, then range-checks every entry one per cycle.
- On a clean frame, commits the whole frame atomically to the live route-select bus that drives the tile's tri-state muxes; on any failure the live bus is left untouched.
- Sits between the configuration port controller and each switch-matrix instance.

Parameters:
- N_TB, 5, wires per top/bottom side.
- N_LR, 4, wires per left/right side.
- ENTRY_W, 6, bits per route entry: [2:0] side code, [5:3] wire index.
- Derived (localparam, not overridable): NUM_ENT = 2*N_TB+2*N_LR = 18; CFG_W = NUM_ENT*ENTRY_W = 108.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin loading a new frame
- cfg_in  in  1  serial frame data
- cfg_valid  in  1  cfg_in qualifier; one bit is accepted per cycle when high in LOAD/PAR
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse: frame committed
- err  out  1  one-cycle pulse: frame rejected
- err_code  out  2  0 none, 1 illegal side, 2 index out of range, 3 parity; held until next start
- err_entry  out  5  entry number of the first failing entry; held until next start
- cfg_bus  out  CFG_W  live routing configuration; entry k occupies [6k+5:6k]

Behaviour:
- Entry order k: top0..4 = 0..4, bottom0..4 = 5..9, left0..3 = 10..13, right0..3 = 14..17.
- Side code: 0 = float (z), 1 = top, 2 = right, 3 = bottom, 4 = left; codes 5..7 are illegal.
- Index legality: sides 1/3 require idx < N_TB; sides 2/4 require idx < N_LR; side 0 ignores idx.
- Reset (async, rst_n low): state IDLE, cfg_bus = 0 (all wires float), shadow = 0, counters = 0, busy/done/err = 0, err_code = 0, err_entry = 0. Reset asserted mid-operation aborts the frame and also clears cfg_bus.
- Frame format: MSB-first. Shadow shifts left with cfg_in entering bit 0, so the first accepted bit ends at bit 107.
- FSM states: IDLE, LOAD, PAR, CHECK, COMMIT, FAIL.
- IDLE: start=1 moves to LOAD; bit counter cleared; err_code and err_entry cleared. Start is ignored in every other state.
- LOAD:
  - Each cycle with cfg_valid=1 shifts one bit and increments the counter.
  - cfg_valid=0 stalls with no timeout.
  - The cycle that accepts bit 108 moves to PAR (macro defined) or CHECK (macro undefined).
- CHECK:
  - Entry pointer starts at 0 and examines one entry per cycle.
  - The first illegal entry sets err_code/err_entry and moves to FAIL.
  - Side fault takes priority over index fault within the same entry.
  - After entry 17 passes, moves to COMMIT. CHECK lasts 18 cycles on a clean frame.
- COMMIT: one cycle; cfg_bus <= shadow; done=1; moves to IDLE.
- FAIL: one cycle; err=1; cfg_bus unchanged; moves to IDLE.
- Latency, clean frame, continuous cfg_valid, macro undefined: done is high in cycle 1+108+18 = 127 after the start cycle (cycle 0).
- cfg_bus changes only in COMMIT or on reset. It is never partially updated.
- busy is a registered output, high from the cycle after start through the COMMIT/FAIL cycle.

Optional Feature:
- Macro SWM_CFG_PARITY_EN.
- Defined:
  - PAR state accepts one extra bit under cfg_valid; that bit is even parity over the 108 frame bits.
  - A running XOR is kept during LOAD.
  - Mismatch: err_code = 3, err_entry = 0, move to FAIL without entering CHECK.
  - Match: move to CHECK.
  - Clean-frame latency becomes 128.
- Undefined: PAR state and the parity logic are absent; a frame is exactly 108 bits.

Test Plan:
- Reset, then all-zero frame with continuous cfg_valid -> done at cycle 127 (128 with macro), cfg_bus = 0, err_code = 0.
- Frame with entry 0 = 6'b001_011 (bottom[1]) and entry 14 = 6'b011_100 (left[3]), others 0 -> done; cfg_bus[5:0] = 6'h0B, cfg_bus[89:84] = 6'h1C.
- Load a valid frame, then a frame with entry 10 = side 2 idx 4 -> err pulse, err_code = 2, err_entry = 10, cfg_bus still equals the first frame.
- Frame with entry 3 side 7 and entry 5 side 1 idx 6 -> err_code = 1, err_entry = 3 (first failure reported).
- cfg_valid toggled every other cycle plus start pulses during LOAD -> same result as a continuous load; starts ignored; done delayed by exactly the idle cycles.
- rst_n low after 50 bits of a frame that follows a committed frame -> cfg_bus = 0, busy = 0 immediately. With the macro defined, a flipped parity bit -> err_code = 3, err_entry = 0.
